sd_kin_sequencer: RTL and testbench
===================================

// Module: sd_kin_sequencer
// PURPOSE
//  Programmable frequency-word scheduler for the two-piece sigma-delta generator.
//  Holds a table of up to DEPTH kin words and steps through them, each for a programmed dwell.
//  Drives the generator's kin input and its active-high reset, so that each new tone starts
//  from a clean modulator state. Optional gap between tones, and optional looping.
// PARAMETERS
//  BITWIDTH  32  width of each kin word (matches generator BITWIDTH)
//  DEPTH     8   table entries (power of 2, >=2); AW = $clog2(DEPTH)
//  CNTW      24  dwell counter width
// PORTS
//  clk          in   1         system clock
//  reset_n      in   1         async active-low reset
//  cfg_we       in   1         table write strobe
//  cfg_addr     in   AW        table write address
//  cfg_wdata    in   BITWIDTH  table write data
//  num_entries  in   AW+1      entries to play (1..DEPTH)
//  dwell        in   CNTW      cycles each tone is active (gen_reset low)
//  gap          in   8         cycles of gen_reset high between tones
//  loop_en      in   1         1 = wrap from last entry to entry 0 indefinitely
//  start        in   1         1-cycle start request
//  stop         in   1         1-cycle abort request
//  kin_out      out  BITWIDTH  kin to generator
//  gen_reset    out  1         active-high reset to generator
//  kin_valid    out  1         1-cycle pulse when kin_out takes a new entry
//  busy         out  1         sequence in progress
//  done         out  1         1-cycle pulse at normal (non-loop) completion
//  cur_idx      out  AW        index of entry currently on kin_out
// BEHAVIOUR
//  Reset: all outputs 0 except gen_reset=1; table cleared to 0; state IDLE.
//  Table: written on clk when cfg_we && !busy; writes while busy are dropped.
//  Config sampling: num_entries/dwell/gap/loop_en are latched at start acceptance; later changes
//   have no effect until the next start.
//  States: IDLE, LOAD, DWELL, GAP.
//   IDLE : busy=0, gen_reset=1, kin_out holds its last value. Start is accepted when
//          start && !stop && 1<=num_entries<=DEPTH; otherwise start is ignored (no done).
//   LOAD : 1 cycle. kin_out<=table[idx], cur_idx<=idx, kin_valid=1, gen_reset=1, busy=1.
//          Entered on the clock edge that samples start, so latency start->kin_valid = 1 edge.
//   DWELL: gen_reset=0 for exactly max(dwell,1) cycles; dwell==0 is treated as 1.
//          At expiry:
//          - idx<num-1: go to GAP, idx+1.
//          - idx==num-1 && loop_en: go to GAP, idx=0.
//          - idx==num-1 && !loop_en: go to IDLE, done=1 for 1 cycle, busy=0.
//   GAP  : gen_reset=1 for gap cycles, then LOAD. gap==0 skips GAP (DWELL->LOAD directly).
//  Period per tone = 1 + dwell + gap cycles. Non-loop run is busy for N*(1+dwell)+(N-1)*gap cycles.
//  stop: from any non-IDLE state -> IDLE on the next edge; gen_reset=1; no done; kin_out held.
//   stop in IDLE: no effect. start and stop together: stop wins.
//  start while busy: ignored. cfg_we while busy: ignored; the played table is unchanged.
//  Async reset mid-run: immediate return to reset values; the table is cleared.
//  kin_out changes only in LOAD, so it is stable for the whole DWELL and GAP.
// TESTING
//  1 Reset: reset_n=0 -> gen_reset=1, kin_out=0, busy=0, done=0, kin_valid=0.
//  2 Single tone: table[0]=0x082EFFFF, num=1, dwell=100, gap=0, start -> kin_valid on next edge;
//    gen_reset low for exactly 100 cycles; done pulse; busy high 101 cycles.
//  3 Multi-tone: num=3, dwell=10, gap=4, entries A/B/C -> kin_out sequence A,B,C; 3 kin_valid pulses
//    15 cycles apart; gen_reset high 5 cycles between tones (1 GAP-equivalent + LOAD); done after C.
//  4 Loop + stop: num=2, loop_en=1 -> A,B,A,B... with no done; stop mid-DWELL -> IDLE next edge,
//    gen_reset=1, done never asserted.
//  5 Corners: num=0 or 9 (DEPTH=8) start -> ignored; dwell=0 -> 1-cycle tones;
//    start+stop same cycle -> stays IDLE.
//  6 Busy protection: cfg_we to the active entry mid-run -> played value unchanged;
//    start while busy -> ignored; after done, the write succeeds.

Source files
------------

// File: rtl/sd_kin_sequencer.sv
// sd_kin_sequencer: steps a sigma-delta generator through a table of kin words.
// Each entry plays for a programmed dwell with gen_reset low, optionally separated
// by a gap with gen_reset high, and the sequence can wrap around indefinitely.
// Output handshake: kin_valid is a 1-cycle pulse (no ready) issued on the cycle
// kin_out takes a new table entry; kin_out and cur_idx then hold until the next
// pulse. done is a 1-cycle pulse at normal completion, never after a stop.
// dbg_state mirrors the internal state for observation.
module sd_kin_sequencer #(
    parameter int BITWIDTH = 32,
    parameter int DEPTH    = 8,
    parameter int CNTW     = 24,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [BITWIDTH-1:0] cfg_wdata,
    input  logic [AW:0]         num_entries,
    input  logic [CNTW-1:0]     dwell,
    input  logic [7:0]          gap,
    input  logic                loop_en,
    input  logic                start,
    input  logic                stop,
    output logic [BITWIDTH-1:0] kin_out,
    output logic                gen_reset,
    output logic                kin_valid,
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       cur_idx,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DWELL = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t              state;
    logic [BITWIDTH-1:0] tbl [DEPTH];
    logic [AW-1:0]       idx;
    logic [AW-1:0]       last_q;
    logic [CNTW-1:0]     dwell_m1_q;
    logic [7:0]          gap_q;
    logic                loop_q;
    logic [CNTW-1:0]     cnt;

    logic                start_ok;
    logic [AW-1:0]       nxt_idx;
    logic [CNTW-1:0]     dwell_eff;

    assign dbg_state = state;

    // Start acceptance, next table index and the dwell==0 -> 1 substitution
    always_comb begin
        start_ok  = start && !stop && (num_entries != '0)
                    && (num_entries <= (AW+1)'(DEPTH));
        nxt_idx   = (idx == last_q) ? '0 : idx + 1'b1;
        dwell_eff = (dwell == '0) ? CNTW'(1) : dwell;
    end

    // Table storage: writable only while no sequence is playing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
        end else if (cfg_we && !busy) begin
            tbl[cfg_addr] <= cfg_wdata;
        end
    end

    // Sequencer FSM with registered outputs; stop overrides everything while active
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            last_q     <= '0;
            dwell_m1_q <= '0;
            gap_q      <= '0;
            loop_q     <= 1'b0;
            cnt        <= '0;
            kin_out    <= '0;
            gen_reset  <= 1'b1;
            kin_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cur_idx    <= '0;
        end else begin
            kin_valid <= 1'b0;
            done      <= 1'b0;
            if (state != S_IDLE && stop) begin
                state     <= S_IDLE;
                busy      <= 1'b0;
                gen_reset <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        gen_reset <= 1'b1;
                        if (start_ok) begin
                            last_q     <= AW'(num_entries - (AW+1)'(1));
                            dwell_m1_q <= dwell_eff - CNTW'(1);
                            gap_q      <= gap;
                            loop_q     <= loop_en;
                            idx        <= '0;
                            kin_out    <= tbl[0];
                            cur_idx    <= '0;
                            kin_valid  <= 1'b1;
                            busy       <= 1'b1;
                            state      <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        gen_reset <= 1'b0;
                        cnt       <= dwell_m1_q;
                        state     <= S_DWELL;
                    end
                    S_DWELL: begin
                        if (cnt == '0) begin
                            gen_reset <= 1'b1;
                            if (idx == last_q && !loop_q) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                idx <= nxt_idx;
                                if (gap_q == '0) begin
                                    kin_out   <= tbl[nxt_idx];
                                    cur_idx   <= nxt_idx;
                                    kin_valid <= 1'b1;
                                    state     <= S_LOAD;
                                end else begin
                                    cnt   <= CNTW'(gap_q) - CNTW'(1);
                                    state <= S_GAP;
                                end
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (cnt == '0) begin
                            kin_out   <= tbl[idx];
                            cur_idx   <= idx;
                            kin_valid <= 1'b1;
                            state     <= S_LOAD;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_kin_sequencer.sv
// Bench for sd_kin_sequencer: expected tone events (value, index, cycle) and done
// cycles are computed from the tone-period rules and queued when a run starts;
// a negedge monitor pops and compares them as the DUT pulses kin_valid / done.
module tb_sd_kin_sequencer;
    localparam int BW    = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CNTW  = 24;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            cfg_we;
    logic [AW-1:0]   cfg_addr;
    logic [BW-1:0]   cfg_wdata;
    logic [AW:0]     num_entries;
    logic [CNTW-1:0] dwell;
    logic [7:0]      gap;
    logic            loop_en;
    logic            start;
    logic            stop;
    logic [BW-1:0]   kin_out;
    logic            gen_reset;
    logic            kin_valid;
    logic            busy;
    logic            done;
    logic [AW-1:0]   cur_idx;
    logic [1:0]      dbg_state;

    sd_kin_sequencer #(.BITWIDTH(BW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .num_entries(num_entries), .dwell(dwell), .gap(gap),
        .loop_en(loop_en), .start(start), .stop(stop), .kin_out(kin_out),
        .gen_reset(gen_reset), .kin_valid(kin_valid), .busy(busy), .done(done),
        .cur_idx(cur_idx), .dbg_state(dbg_state)
    );

    // clock / cycle stamp
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    logic [BW-1:0] exp_q[$];
    int            exp_idx_q[$];
    int            exp_cyc_q[$];
    int            done_cyc_q[$];
    logic [BW-1:0] mtab [DEPTH];
    int            busy_cnt = 0;
    int            low_cnt  = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            exp_idx_q.delete();
            exp_cyc_q.delete();
            done_cyc_q.delete();
        end else begin
            if (busy) busy_cnt++;
            if (!gen_reset) low_cnt++;
            if (kin_valid) begin
                if (exp_q.size() == 0) check("kin_valid_unexpected", cyc, -1);
                else begin
                    check("kin_out", kin_out, exp_q.pop_front());
                    check("cur_idx", cur_idx, exp_idx_q.pop_front());
                    check("kin_valid_cycle", cyc, exp_cyc_q.pop_front());
                end
            end
            if (done) begin
                if (done_cyc_q.size() == 0) check("done_unexpected", cyc, -1);
                else check("done_cycle", cyc, done_cyc_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int a, input logic [BW-1:0] d, input bit model);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(a);
        cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
        if (model) mtab[a] = d;
    endtask

    task automatic scramble_cfg();
        num_entries = (AW+1)'($urandom);
        dwell       = CNTW'($urandom_range(0, 3));
        gap         = 8'($urandom);
        loop_en     = 1'($urandom);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (i == budget) check({name, "_timeout"}, i, -1);
        tick();
    endtask

    task automatic check_drained(input string name);
        check({name, "_kin_q_left"}, exp_q.size(), 0);
        check({name, "_done_q_left"}, done_cyc_q.size(), 0);
    endtask

    // one non-looping run: model events queued, then waited on and totals checked
    task automatic run_once(input int num, input int dw, input int gp, input string name);
        int s, d, p, b0, l0, eb, el;
        num_entries = (AW+1)'(num);
        dwell       = CNTW'(dw);
        gap         = 8'(gp);
        loop_en     = 1'b0;
        start       = 1'b1;
        tick();
        start = 1'b0;
        s  = cyc;
        b0 = busy_cnt;
        l0 = low_cnt;
        d  = (dw == 0) ? 1 : dw;
        p  = 1 + d + gp;
        eb = 0;
        el = 0;
        if (num >= 1 && num <= DEPTH) begin
            for (int i = 0; i < num; i++) begin
                exp_q.push_back(mtab[i]);
                exp_idx_q.push_back(i);
                exp_cyc_q.push_back(s + i * p);
            end
            done_cyc_q.push_back(s + (num - 1) * p + 1 + d);
            eb = num * (1 + d) + (num - 1) * gp;
            el = num * d;
        end
        scramble_cfg();
        wait_idle(num * p + 20, name);
        check({name, "_busy_cycles"}, busy_cnt - b0, eb);
        check({name, "_low_cycles"}, low_cnt - l0, el);
        check_drained(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, d, p, b0, stop_cyc;
        reset_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        num_entries = '0; dwell = '0; gap = '0; loop_en = 1'b0;
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < DEPTH; i++) mtab[i] = '0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_gen_reset", gen_reset, 1);
        check("rst_kin_out", kin_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_kin_valid", kin_valid, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // single tone
        write_entry(0, 32'h082E_FFFF, 1);
        run_once(1, 100, 0, "single");

        // multi-tone with gap
        write_entry(0, $urandom, 1);
        write_entry(1, $urandom, 1);
        write_entry(2, $urandom, 1);
        run_once(3, 10, 4, "multi");

        // loop then stop mid-dwell (period 9, stop sampled at offset 5 into a tone)
        write_entry(0, $urandom, 1);
        write_entry(1, $urandom, 1);
        num_entries = 2; dwell = 6; gap = 2; loop_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        s = cyc;
        b0 = busy_cnt;
        p = 1 + 6 + 2;
        stop_cyc = s + 40 + 1;
        for (int i = 0; s + i * p < stop_cyc; i++) begin
            exp_q.push_back(mtab[i % 2]);
            exp_idx_q.push_back(i % 2);
            exp_cyc_q.push_back(s + i * p);
        end
        scramble_cfg();
        repeat (40) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        @(negedge clk);
        check("stop_gen_reset", gen_reset, 1);
        check("stop_busy", busy, 0);
        check("loop_busy_cycles", busy_cnt - b0, 41);
        tick();
        repeat (5) tick();
        check_drained("loop");

        // corners: out-of-range counts, zero dwell, start+stop together
        run_once(0, 5, 0, "num0");
        run_once(9, 5, 0, "num9");
        write_entry(2, $urandom, 1);
        run_once(3, 0, 0, "dwell0");
        b0 = busy_cnt;
        num_entries = 2; dwell = 3; gap = 0; loop_en = 1'b0;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        repeat (3) tick();
        check("startstop_busy_cycles", busy_cnt - b0, 0);
        check_drained("startstop");

        // busy protection: writes and start mid-run are dropped
        write_entry(0, 32'h1111_0000, 1);
        write_entry(1, 32'h2222_0000, 1);
        num_entries = 2; dwell = 20; gap = 3; loop_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        s = cyc;
        b0 = busy_cnt;
        p = 1 + 20 + 3;
        exp_q.push_back(mtab[0]); exp_idx_q.push_back(0); exp_cyc_q.push_back(s);
        exp_q.push_back(mtab[1]); exp_idx_q.push_back(1); exp_cyc_q.push_back(s + p);
        done_cyc_q.push_back(s + p + 1 + 20);
        repeat (4) tick();
        write_entry(0, 32'hDEAD_0000, 0);
        write_entry(1, 32'hDEAD_0001, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(100, "busyprot");
        check("busyprot_busy_cycles", busy_cnt - b0, 2 * 21 + 3);
        check_drained("busyprot");
        write_entry(0, 32'h5A5A_1234, 1);
        run_once(1, 5, 0, "after_done_write");

        // randomized runs
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 3; k++) write_entry($urandom_range(0, DEPTH - 1), $urandom, 1);
            run_once($urandom_range(1, DEPTH), $urandom_range(0, 12), $urandom_range(0, 5), "random");
        end

        // async reset mid-run clears the table
        write_entry(0, 32'hA5A5_0001, 1);
        write_entry(1, 32'hA5A5_0002, 1);
        num_entries = 4; dwell = 30; gap = 2; loop_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.push_back(mtab[0]); exp_idx_q.push_back(0); exp_cyc_q.push_back(cyc);
        repeat (10) tick();
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_gen_reset", gen_reset, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_kin_out", kin_out, 0);
        for (int i = 0; i < DEPTH; i++) mtab[i] = '0;
        tick();
        reset_n = 1'b1;
        tick();
        run_once(2, 3, 1, "post_reset");

        check_drained("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
